// File: rtl/fft_ctrl.sv
// fft_ctrl: sequencer for a radix-2^2 SDF FFT pipeline (BFI/BFII stages).
// Converts a valid/ready input stream into the pipeline advance enable,
// per-butterfly control bits and BFII -j rotate selects, zero-pads partial
// frames, flushes the pipeline, and tags outputs with valid/last/index.
//
// Optional feature macro: FFT_CTRL_BITREV_IDX_EN
//   defined   -> out_idx carries the bit-reversed (natural order) index
//   undefined -> out_idx is tied to 0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame in progress, counters cleared, waiting for a sample
// RUN   | accepting samples, one advance per accepted sample
// PAD   | zero-filling the remainder of a partial frame
// FLUSH | issuing D_T zero bubbles to drain the pipeline
module fft_ctrl #(
  parameter int  N_POINTS = 16,
  parameter int  BF_LAT   = 1,
  localparam int LOG2N    = $clog2(N_POINTS),
  localparam int S        = LOG2N / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             en,
  output logic             zero_in,
  output logic [2*S-1:0]   ctrl,
  output logic [S-1:0]     rot,
  output logic             out_valid,
  output logic             out_last,
  output logic [LOG2N-1:0] out_idx,
  output logic             busy
);

  localparam int D_T = N_POINTS - 1 + 2 * S * BF_LAT;
  localparam int FW  = $clog2(D_T + 1);

  localparam logic [FW-1:0]    D_T_F    = FW'(D_T);
  localparam logic [FW-1:0]    BUB_INIT = FW'(D_T - 1);
  localparam logic [LOG2N-1:0] D_T_G    = LOG2N'(D_T);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAD   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LOG2N-1:0] g_q, g_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [FW-1:0]    bub_q, bub_d;
  logic             out_valid_q, out_last_q;
  logic             adv_out;
  logic [LOG2N-1:0] oidx_nat;

  // Stream handshake and advance; everything is forced quiet while rst is high
  always_comb begin
    in_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_RUN));
    zero_in  = ~rst & ((state_q == ST_PAD) | (state_q == ST_FLUSH));
    en       = zero_in | (in_valid & in_ready);
    busy     = ~rst & (state_q != ST_IDLE);
  end

  // Next-state and counter update; the flush decision sees g after this cycle's advance
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    fill_d  = fill_q;
    bub_d   = bub_q;
    if (en) begin
      g_d = g_q + 1'b1;
      if (fill_q != D_T_F) fill_d = fill_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN: begin
        if (flush) begin
          if (g_d != '0) begin
            state_d = ST_PAD;
          end else if (fill_d != '0) begin
            state_d = ST_FLUSH;
            bub_d   = BUB_INIT;
          end
        end
      end
      ST_PAD: begin
        if (g_d == '0) begin
          state_d = ST_FLUSH;
          bub_d   = BUB_INIT;
        end
      end
      ST_FLUSH: begin
        if (bub_q == '0) begin
          state_d = ST_IDLE;
          g_d     = '0;
          fill_d  = '0;
        end else begin
          bub_d = bub_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      fill_q  <= '0;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      fill_q  <= fill_d;
      bub_q   <= bub_d;
    end
  end

  // Butterfly controls; a stage stays at 0 until its first real sample arrives
  for (genvar j = 0; j < 2 * S; j++) begin : g_bf
    localparam int DJ = N_POINTS - (N_POINTS >> j) + j * BF_LAT;
    logic [LOG2N-1:0] c;
    logic             primed;
    assign c = g_q - LOG2N'(DJ);
    if (j == 0) begin : g_first
      assign primed = 1'b1;
    end else begin : g_later
      assign primed = (fill_q >= FW'(DJ));
    end
    assign ctrl[j] = ~rst & primed & c[LOG2N-1-j];
    if (j % 2 == 1) begin : g_rot
      assign rot[j/2] = ~rst & primed & c[LOG2N-j] & ~c[LOG2N-j-1];
    end
  end

  // fill saturates at D_T, so equality marks an output advance
  assign adv_out  = en & (fill_q == D_T_F);
  assign oidx_nat = g_q - D_T_G;

  // Output tag registers, aligned with the last stage's registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= adv_out;
      out_last_q  <= adv_out & (oidx_nat == '1);
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

`ifdef FFT_CTRL_BITREV_IDX_EN
  logic [LOG2N-1:0] idx_rev;
  logic [LOG2N-1:0] out_idx_q;

  // Bit reversal turns the SDF output position into natural frequency order
  always_comb begin
    idx_rev = '0;
    for (int b = 0; b < LOG2N; b++) idx_rev[b] = oidx_nat[LOG2N-1-b];
  end

  // Index register, zero whenever the output is not valid
  always_ff @(posedge clk) begin
    if (rst) out_idx_q <= '0;
    else     out_idx_q <= adv_out ? idx_rev : '0;
  end

  assign out_idx = out_idx_q;
`else
  assign out_idx = '0;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl with N_POINTS=16, BF_LAT=1 (D = 0,9,14,17; D_T = 19).
module tb_fft_ctrl;

  logic       clk = 1'b0;
  logic       rst, in_valid, flush;
  logic       in_ready, en, zero_in, out_valid, out_last, busy;
  logic [3:0] ctrl, out_idx;
  logic [1:0] rot;

  int checks = 0;
  int errors = 0;

  // snapshot of DUT outputs taken at the falling edge of the last tick
  logic       s_in_ready, s_en, s_zero, s_ov, s_ol, s_busy;
  logic [3:0] s_ctrl, s_oidx;
  logic [1:0] s_rot;

  // per-advance and per-output traces
  logic [3:0] ctrl_tr [$];
  logic [1:0] rot_tr  [$];
  logic       z_tr    [$];
  int         out_adv [$];
  logic [3:0] oidx_tr [$];
  logic       olast_tr[$];

  int         dj_tab [4]  = '{0, 9, 14, 17};
  logic [3:0] br_tab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                              4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

  always #5 clk = ~clk;

  fft_ctrl #(.N_POINTS(16), .BF_LAT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .en       (en),
    .zero_in  (zero_in),
    .ctrl     (ctrl),
    .rot      (rot),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_idx  (out_idx),
    .busy     (busy)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: sample at the falling edge, then step past the rising edge
  task automatic tick();
    @(negedge clk);
    s_in_ready = in_ready; s_en = en; s_zero = zero_in; s_ov = out_valid;
    s_ol = out_last; s_busy = busy; s_ctrl = ctrl; s_oidx = out_idx; s_rot = rot;
    if (out_valid) begin
      out_adv.push_back(ctrl_tr.size() - 1);
      oidx_tr.push_back(out_idx);
      olast_tr.push_back(out_last);
    end
    if (en) begin
      ctrl_tr.push_back(ctrl);
      rot_tr.push_back(rot);
      z_tr.push_back(zero_in);
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_tr();
    ctrl_tr.delete(); rot_tr.delete(); z_tr.delete();
    out_adv.delete(); oidx_tr.delete(); olast_tr.delete();
  endtask

  // tick until busy drops (bounded); returns advances seen
  task automatic drain(output int nb);
    int n;
    n  = 0;
    nb = 0;
    do begin
      tick();
      nb += int'(s_en);
      n++;
    end while (s_busy && n < 100);
  endtask

  // expected control bits at advance k of an uninterrupted stream from IDLE
  function automatic logic [3:0] exp_ctrl(int k);
    logic [3:0] r, c;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      if (k >= dj_tab[j]) begin
        c    = 4'(k - dj_tab[j]);
        r[j] = c[3-j];
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_rot(int k);
    logic [1:0] r;
    logic [3:0] c;
    r = '0;
    c = 4'(k - 9);
    if (k >= 9) r[0] = c[3] & ~c[2];
    c = 4'(k - 17);
    if (k >= 17) r[1] = c[1] & ~c[0];
    return r;
  endfunction

  function automatic logic [3:0] exp_idx(int i);
`ifdef FFT_CTRL_BITREV_IDX_EN
    return br_tab[i % 16];
`else
    return 4'd0;
`endif
  endfunction

  // compare traces of a run: nadv advances, zero_in from advance zfrom, nout outputs
  task automatic check_run(string tag, int nadv, int zfrom, int nout);
    check({tag, "_nadv"}, 32'(ctrl_tr.size()), 32'(nadv));
    for (int k = 0; k < ctrl_tr.size() && k < nadv; k++) begin
      check($sformatf("%s_ctrl%0d", tag, k), 32'(ctrl_tr[k]), 32'(exp_ctrl(k)));
      check($sformatf("%s_rot%0d", tag, k), 32'(rot_tr[k]), 32'(exp_rot(k)));
      check($sformatf("%s_zero%0d", tag, k), 32'(z_tr[k]), 32'(k >= zfrom));
    end
    check({tag, "_nout"}, 32'(out_adv.size()), 32'(nout));
    for (int i = 0; i < out_adv.size() && i < nout; i++) begin
      check($sformatf("%s_oadv%0d", tag, i), 32'(out_adv[i]), 32'(19 + i));
      check($sformatf("%s_oidx%0d", tag, i), 32'(oidx_tr[i]), 32'(exp_idx(i)));
      check($sformatf("%s_olast%0d", tag, i), 32'(olast_tr[i]), 32'((i % 16) == 15));
    end
  endtask

  initial begin
    int nb, acc, guard;

    // reset held 3 cycles with in_valid high
    rst = 1'b1; in_valid = 1'b1; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", 32'(s_in_ready), 32'd0);
      check("rst_en", 32'(s_en), 32'd0);
      check("rst_zero", 32'(s_zero), 32'd0);
      check("rst_ctrl", 32'(s_ctrl), 32'd0);
      check("rst_rot", 32'(s_rot), 32'd0);
      check("rst_busy", 32'(s_busy), 32'd0);
      if (i > 0) begin
        check("rst_ov", 32'(s_ov), 32'd0);
        check("rst_ol", 32'(s_ol), 32'd0);
        check("rst_oidx", 32'(s_oidx), 32'd0);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("idle_in_ready", 32'(s_in_ready), 32'd1);
    check("idle_busy", 32'(s_busy), 32'd0);
    check("idle_ctrl", 32'(s_ctrl), 32'd0);
    clear_tr();

    // one full frame then flush
    in_valid = 1'b1;
    repeat (16) tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(nb);
    check("frame_bubbles", 32'(nb), 32'd19);
    check("frame_idle", 32'(s_busy), 32'd0);
    for (int k = 0; k < 16 && k < ctrl_tr.size(); k++)
      check($sformatf("frame_ctrl0_%0d", k), 32'(ctrl_tr[k][0]), 32'(k >= 8));
    for (int k = 0; k < 14 && k < ctrl_tr.size(); k++)
      check($sformatf("frame_ctrl1_%0d", k), 32'(ctrl_tr[k][1]), 32'(k >= 13));
    check_run("frame", 35, 16, 16);
    clear_tr();

    // partial frame: 5 samples, flush, 11 pads, 19 bubbles
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1;
    tick();
    check("pad_in_ready", 32'(s_in_ready), 32'd0);
    check("pad_zero", 32'(s_zero), 32'd1);
    check("pad_en", 32'(s_en), 32'd1);
    check("pad_busy", 32'(s_busy), 32'd1);
    in_valid = 1'b0;
    drain(nb);
    check("pad_advances", 32'(nb), 32'd29);
    check("pad_idle", 32'(s_busy), 32'd0);
    check_run("pad", 35, 5, 16);
    clear_tr();

    // 32 samples with random stalls, must match the uninterrupted sequence
    acc = 0; guard = 0;
    while (acc < 32 && guard < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      tick();
      acc += int'(s_en);
      guard++;
    end
    check("stall_accepted", 32'(acc), 32'd32);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(nb);
    check("stall_bubbles", 32'(nb), 32'd19);
    check("stall_idle", 32'(s_busy), 32'd0);
    check_run("stall", 51, 32, 32);
    clear_tr();

    // reset in the middle of FLUSH, then a fresh frame
    in_valid = 1'b1;
    repeat (16) tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check("mrst_en", 32'(s_en), 32'd0);
    rst = 1'b0;
    tick();
    check("mrst_busy", 32'(s_busy), 32'd0);
    check("mrst_in_ready", 32'(s_in_ready), 32'd1);
    check("mrst_en_after", 32'(s_en), 32'd0);
    check("mrst_zero", 32'(s_zero), 32'd0);
    check("mrst_ctrl", 32'(s_ctrl), 32'd0);
    check("mrst_rot", 32'(s_rot), 32'd0);
    check("mrst_ov", 32'(s_ov), 32'd0);
    check("mrst_ol", 32'(s_ol), 32'd0);
    check("mrst_oidx", 32'(s_oidx), 32'd0);
    clear_tr();
    in_valid = 1'b1;
    repeat (16) tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(nb);
    check("mrst_frame_bubbles", 32'(nb), 32'd19);
    check_run("mrst", 35, 16, 16);
    clear_tr();

    // flush while idle is ignored
    flush = 1'b1;
    repeat (3) begin
      tick();
      check("iflush_en", 32'(s_en), 32'd0);
      check("iflush_busy", 32'(s_busy), 32'd0);
    end
    flush = 1'b0;
    tick();
    check("iflush_busy_after", 32'(s_busy), 32'd0);
    check("iflush_in_ready", 32'(s_in_ready), 32'd1);
    check("iflush_ov", 32'(s_ov), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
